ysyx_22050499_idc: RTL and testbench

YSYX_22050499_IDC -- requirements
Module: ysyx_22050499_IDC

---
 rtl/ysyx_22050499_idc.sv | 115 +++++++++++
 tb/tb_ysyx_22050499_idc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050499_idc.sv
// Instruction decode stage: a one-entry valid/ready buffer that registers the
// instruction, its PC and the immediate-extender select. Optional illegal-opcode
// flagging is enabled by defining YSYX_22050499_ILLEGAL_TRAP_EN.
module ysyx_22050499_idc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [2:0]  ExtOp,
  output logic        illegal,
  input  logic        flush,
  output logic [31:0] dec_cnt
);

`ifdef YSYX_22050499_ILLEGAL_TRAP_EN
  localparam logic ILLEGAL_TRAP = 1'b1;
`else
  localparam logic ILLEGAL_TRAP = 1'b0;
`endif

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  ext_q, ext_d;
  logic        ill_q, ill_d;
  logic [31:0] cnt_q, cnt_d;

  logic [2:0]  dec_ext;
  logic        dec_ill;
  logic        load;
  logic        out_hs;

  always_comb begin
    dec_ext = EXT_I;
    dec_ill = 1'b0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0011011:              dec_ext = EXT_I;
      7'b0110111, 7'b0010111:              dec_ext = EXT_U;
      7'b0100011:                          dec_ext = EXT_S;
      7'b1100011:                          dec_ext = EXT_B;
      7'b1101111:                          dec_ext = EXT_J;
      7'b0110011, 7'b0111011:              dec_ext = EXT_I;
      default:                             dec_ill = ILLEGAL_TRAP;
    endcase
    // Compressed/non-32-bit encodings are never decodable here.
    if (in_inst[1:0] != 2'b11) dec_ill = ILLEGAL_TRAP;
  end

  assign in_ready = ~flush & ((state_q == EMPTY) | out_ready);
  assign load     = in_valid & in_ready;
  assign out_hs   = (state_q == FULL) & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    ext_d   = ext_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (out_hs) cnt_d = cnt_q + 32'd1;
    // flush already forces load low via in_ready, so it wins over both events
    if (flush) begin
      state_d = EMPTY;
    end else if (load) begin
      state_d = FULL;
      inst_d  = in_inst;
      pc_d    = in_pc;
      ext_d   = dec_ext;
      ill_d   = dec_ill;
    end else if (out_hs) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
      ext_q   <= 3'd0;
      ill_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      ext_q   <= ext_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
  assign ExtOp     = ext_q;
  assign illegal   = ill_q;
  assign dec_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22050499_idc.sv
// Self-checking bench for ysyx_22050499_idc: directed scenarios plus a random run,
// all compared against a behavioural one-entry buffer model.
module tb_ysyx_22050499_idc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  ExtOp;
  logic        illegal;
  logic        flush;
  logic [31:0] dec_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit          m_full;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

`ifdef YSYX_22050499_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_22050499_idc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .ExtOp     (ExtOp),
    .illegal   (illegal),
    .flush     (flush),
    .dec_cnt   (dec_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  // extender select from the opcode table; unknown opcodes fall back to I
  function automatic logic [2:0] ref_ext(input logic [31:0] inst);
    int opc = int'(inst[6:0]);
    if (opc == 'h37 || opc == 'h17) return 3'd1;
    if (opc == 'h23) return 3'd2;
    if (opc == 'h63) return 3'd3;
    if (opc == 'h6F) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit ref_legal(input logic [31:0] inst);
    int legal_ops[12] = '{'h13, 'h03, 'h67, 'h73, 'h1B, 'h37, 'h17, 'h23, 'h63, 'h6F, 'h33, 'h3B};
    foreach (legal_ops[k]) if (int'(inst[6:0]) == legal_ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ref_ill(input logic [31:0] inst);
    return TRAP_EN && !ref_legal(inst);
  endfunction

  // One clock: drive at the falling edge, compare, then step the model at the rising edge.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit rdy, ld, hs;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    rdy = !fl && (!m_full || ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    if (m_full) begin
      check("out_inst", out_inst, m_inst);
      check("out_pc", out_pc, m_pc);
      check("ExtOp", {29'd0, ExtOp}, {29'd0, ref_ext(m_inst)});
      check("illegal", {31'd0, illegal}, {31'd0, ref_ill(m_inst)});
    end
    check("dec_cnt", dec_cnt, m_cnt);
    $display("cyc v=%0b inst=%08h ordy=%0b fl=%0b | full=%0b cnt=%0d", v, inst, ordy, fl, m_full, m_cnt);
    ld = v && rdy;
    hs = m_full && ordy && !fl;
    @(posedge clk);
    if (hs) m_cnt = m_cnt + 32'd1;
    if (fl) m_full = 1'b0;
    else if (ld) begin m_full = 1'b1; m_inst = inst; m_pc = pc; end
    else if (hs) m_full = 1'b0;
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_inst = '0; m_pc = '0; m_cnt = '0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h37, 7'h17, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h3B};
    logic [31:0] w = $urandom;
    if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(11)];
    return w;
  endfunction

  logic [31:0] b2b_inst[4] = '{32'h123450B7, 32'h00112023, 32'hFE000EE3, 32'h0080006F};
  logic [2:0]  b2b_ext[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] cnt_before;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_ExtOp", {29'd0, ExtOp}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_dec_cnt", dec_cnt, 32'd0);

    // reset while FULL, no clock edge needed
    cycle(1'b1, 32'h00500093, 32'h80000000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00500093, 32'h80000004, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ExtOp", {29'd0, ExtOp}, 32'd0);
    check("midrst_dec_cnt", dec_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("postrst_out_valid", {31'd0, out_valid}, 32'd0);

    // back-to-back stream at full throughput
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, b2b_inst[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      #1 check("b2b_ExtOp", {29'd0, ExtOp}, {29'd0, b2b_ext[i]});
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1 check("b2b_dec_cnt", dec_cnt, 32'd4);

    // backpressure
    cycle(1'b1, 32'h00112023, 32'h200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0080006F, 32'h204, 1'b0, 1'b0);
      #1 check("bp_out_inst", out_inst, 32'h00112023);
    end
    cycle(1'b1, 32'h0080006F, 32'h204, 1'b1, 1'b0);
    #1;
    check("bp_j_ExtOp", {29'd0, ExtOp}, 32'd4);
    check("bp_j_out_inst", out_inst, 32'h0080006F);

    // flush while FULL with an incoming instruction
    cnt_before = m_cnt;
    cycle(1'b1, 32'h00500093, 32'h300, 1'b1, 1'b1);
    #1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_dec_cnt", dec_cnt, cnt_before);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // illegal opcode
    cycle(1'b1, 32'hFFFFFFFF, 32'h400, 1'b0, 1'b0);
    #1;
    check("ill_illegal", {31'd0, illegal}, {31'd0, TRAP_EN});
    check("ill_ExtOp", {29'd0, ExtOp}, 32'd0);

    // counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1 check("wrap_dec_cnt", dec_cnt, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(9) < 7, rand_inst(), $urandom & 32'hFFFFFFFC,
            $urandom_range(1) == 1, $urandom_range(15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
